// File: rtl/mul_pkg.sv
// Shared definitions for the shift-and-add multiplier: controller state encoding
// and a small output bundle reused by the datapath bench and debug logic.
package mul_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,  // idle, waiting for St
    S1 = 2'd1,  // test multiplier bit: add or shift
    S2 = 2'd2,  // shift after an add
    S3 = 2'd3   // done
  } mul_state_e;

  localparam int unsigned StateWidth = 2;

  typedef struct packed {
    logic load;
    logic ad;
    logic sh;
    logic done;
  } mul_ctrl_t;

  localparam mul_ctrl_t CtrlIdle = '{load: 1'b0, ad: 1'b0, sh: 1'b0, done: 1'b0};

  // Ad and Sh share the accumulator write port, so they must never coincide.
  function automatic logic ctrl_legal(mul_ctrl_t c);
    return !(c.ad && c.sh);
  endfunction

endpackage

// File: rtl/mul_control.sv
// Control FSM for a sequential shift-and-add multiplier: registered state,
// Mealy outputs decoded from the state and the current St/M/K inputs.
module mul_control
  import mul_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       St,
  input  logic       M,
  input  logic       K,
  output logic       Load,
  output logic       Ad,
  output logic       Sh,
  output logic       Done,
  output logic [1:0] State
);

  mul_state_e state_q, state_d;
  mul_ctrl_t  ctrl;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl    = CtrlIdle;
    // Outputs stay quiet for the whole reset cycle so an aborted run never pulses Done.
    if (Reset) begin
      case (state_q)
        S0: begin
          ctrl.load = St;
          if (St) state_d = S1;
        end
        S1: begin
          if (M) begin
            ctrl.ad = 1'b1;
            state_d = S2;
          end else begin
            ctrl.sh = 1'b1;
            if (K) state_d = S3;
          end
        end
        S2: begin
          ctrl.sh = 1'b1;
          state_d = K ? S3 : S1;
        end
        S3: begin
          ctrl.done = 1'b1;
          state_d   = S0;
        end
        default: begin
          state_d = S0;
        end
      endcase
    end
  end

  assign Load  = ctrl.load;
  assign Ad    = ctrl.ad;
  assign Sh    = ctrl.sh;
  assign Done  = ctrl.done;
  assign State = state_q;

endmodule

// File: tb/tb_mul_control.sv
// Directed bench for mul_control: each step pushes the expected state/outputs to a
// scoreboard queue, then pops and compares once the combinational outputs settle.
module tb_mul_control;

  logic       clk;
  logic       reset;
  logic       st;
  logic       m;
  logic       k;
  logic       load;
  logic       ad;
  logic       sh;
  logic       done;
  logic [1:0] state;

  typedef struct {
    string      tag;
    logic [1:0] state;
    logic [3:0] outs;  // {load, ad, sh, done}
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mul_control dut (
    .Clk  (clk),
    .Reset(reset),
    .St   (st),
    .M    (m),
    .K    (k),
    .Load (load),
    .Ad   (ad),
    .Sh   (sh),
    .Done (done),
    .State(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge, record expectations, compare 1 time unit later.
  task automatic step(input string tag, input logic r, input logic s, input logic mm,
                      input logic kk, input logic [1:0] e_state, input logic [3:0] e_outs);
    exp_t e;
    exp_t got;
    @(negedge clk);
    reset = r;
    st    = s;
    m     = mm;
    k     = kk;
    e.tag   = tag;
    e.state = e_state;
    e.outs  = e_outs;
    exp_q.push_back(e);
    #1;
    got = exp_q.pop_front();
    checks++;
    assert (state === got.state) else begin
      errors++;
      $error("FAIL %s state got %0d want %0d", got.tag, state, got.state);
    end
    checks++;
    assert ({load, ad, sh, done} === got.outs) else begin
      errors++;
      $error("FAIL %s outs(load,ad,sh,done) got %b want %b", got.tag, {load, ad, sh, done},
             got.outs);
    end
  endtask

  initial begin
    reset = 1'b0;
    st    = 1'b1;
    m     = 1'b0;
    k     = 1'b0;
    //                 Reset St  M     K     State  {L,A,S,D}
    step("reset",      1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000);
    step("start",      1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1000);
    step("s1_shift_a", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0010);
    step("s1_shift_b", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0010);
    step("s1_add",     1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0100);
    step("s2_shift",   1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0010);
    step("s1_add_b",   1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0100);
    step("s2_last",    1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0010);
    step("s3_done",    1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 4'b0001);
    step("s0_ignmk",   1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0000);
    step("s0_ignmk_b", 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000);
    step("start2",     1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1000);
    step("s1_last",    1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010);
    step("s3_done2",   1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0001);
    step("start3",     1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1000);
    step("s1_add3",    1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0100);
    step("abort_s2",   1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0000);
    step("post_abort", 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000);
    step("restart",    1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1000);
    step("hold_s1",    1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0010);
    step("hold_s3",    1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0001);
    step("hold_relod", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1000);
    step("abort_s1",   1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0000);
    step("after_ab1",  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
